// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// access regions, I/O register offsets and the address decoder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_IO  = 2'd1,
    REG_ERR = 2'd2
  } region_t;

  localparam logic [15:0] LED_OFF = 16'h0000;
  localparam logic [15:0] SW_OFF  = 16'h0004;
  localparam logic [15:0] CYC_OFF = 16'h0008;

  // Misalignment is an error whatever region the address falls in.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [15:0] io_hi);
    region_t region;
    if (addr[1:0] != 2'b00) begin
      region = REG_ERR;
    end else if (addr < ram_bytes) begin
      region = REG_RAM;
    end else if (addr[31:16] == io_hi) begin
      region = REG_IO;
    end else begin
      region = REG_ERR;
    end
    return region;
  endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port DEPTH x 32 word RAM with registered read data.
// Storage is deliberately not reset.
module sync_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Write port and registered read port share one address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves one word request at a time from a word RAM
// or a small I/O bank (LEDs, switches, cycle counter).
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LED_W   = 8,
  parameter int          SW_W    = 8,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [LED_W-1:0] led_out,
  input  logic [SW_W-1:0]  sw_in
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  state_t           r_state;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;
  logic [31:0]      r_cycles;

  region_t     w_region;
  logic        w_accept;
  logic        w_ram_we;
  logic        w_ram_re;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_io_rdata;
  logic        w_io_err;
  logic        w_io_led_sel;
  logic        w_io_cyc_sel;
  logic        w_led_wr;
  logic        w_cyc_wr;

  assign w_region = decode_region(req_addr, RAM_BYTES, IO_BASE[31:16]);
  assign w_accept = (r_state == IDLE) && req_valid && !rst;
  assign w_ram_we = w_accept && req_write && (w_region == REG_RAM);
  assign w_ram_re = w_accept && !req_write && (w_region == REG_RAM);

  // I/O register select and read mux, evaluated in the accept cycle.
  always_comb begin
    w_io_rdata   = 32'h0000_0000;
    w_io_err     = 1'b0;
    w_io_led_sel = 1'b0;
    w_io_cyc_sel = 1'b0;
    case (req_addr[15:0])
      LED_OFF: begin
        w_io_rdata   = 32'(r_led);
        w_io_led_sel = 1'b1;
      end
      SW_OFF:  w_io_rdata = 32'(r_sw_sync);
      CYC_OFF: begin
        w_io_rdata   = r_cycles;
        w_io_cyc_sel = 1'b1;
      end
      default: w_io_err = 1'b1;
    endcase
  end

  assign w_led_wr = w_accept && req_write && (w_region == REG_IO) && w_io_led_sel;
  assign w_cyc_wr = w_accept && req_write && (w_region == REG_IO) && w_io_cyc_sel;

  sync_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (req_addr[AW+1:2]),
    .i_wdata (req_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            case (w_region)
              REG_RAM: begin
                if (req_write) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= 32'h0000_0000;
                  r_rsp_err   <= 1'b0;
                end else begin
                  r_state <= RD_WAIT;
                end
              end
              REG_IO: begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_io_err;
                r_rsp_rdata <= (req_write || w_io_err) ? 32'h0000_0000 : w_io_rdata;
              end
              default: begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= 32'h0000_0000;
              end
            endcase
          end
        end
        RD_WAIT: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_ram_rdata;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'h0000_0000;
        end
      endcase
    end
  end

  // LED register, switch synchroniser and cycle counter; a counter write beats the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_cycles  <= 32'h0000_0000;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (w_led_wr) begin
        r_led <= req_wdata[LED_W-1:0];
      end
      r_cycles <= w_cyc_wr ? 32'h0000_0000 : r_cycles + 32'd1;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign led_out   = r_led;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder; expected values are
// worked out by hand and compared through check_eq.
module tb_data_mem_responder;

  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  led_out;
  logic [7:0]  sw_in = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH(1024), .LED_W(8), .SW_W(8), .IO_BASE(IO_BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .led_out   (led_out),
    .sw_in     (sw_in)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns after the response handshake edge (+#1).
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
    int n;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err",   32'(rsp_err),   32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata,      32'h0);
    check_eq("rst_led",       32'(led_out),   32'h0);

    // RAM write then read back.
    xact(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    check_eq("ram_wr_lat", 32'(lat), 32'd1);
    check_eq("ram_wr_rd",  rd, 32'h0);
    check_eq("ram_wr_err", 32'(er), 32'd0);
    check_eq("ready_after_hs", 32'(req_ready), 32'd1);
    xact(1'b0, 32'h10, 32'h0, lat, rd, er);
    check_eq("ram_rd_lat", 32'(lat), 32'd2);
    check_eq("ram_rd_data", rd, 32'hDEADBEEF);
    check_eq("ram_rd_err", 32'(er), 32'd0);

    // LED register; switch register ignores writes without error.
    xact(1'b1, IO_BASE, 32'h1A5, lat, rd, er);
    check_eq("led_wr_lat", 32'(lat), 32'd1);
    check_eq("led_out", 32'(led_out), 32'hA5);
    xact(1'b0, IO_BASE, 32'h0, lat, rd, er);
    check_eq("led_rd", rd, 32'h0000_00A5);
    xact(1'b1, IO_BASE + 32'h4, 32'hFF, lat, rd, er);
    check_eq("sw_wr_err", 32'(er), 32'd0);
    check_eq("sw_wr_rd", rd, 32'h0);

    // Switch synchroniser: two flops of delay.
    sw_in = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    xact(1'b0, IO_BASE + 32'h4, 32'h0, lat, rd, er);
    check_eq("sw_rd", rd, 32'h3C);
    sw_in = 8'h5A;
    xact(1'b0, IO_BASE + 32'h4, 32'h0, lat, rd, er);
    check_eq("sw_rd_old", rd, 32'h3C);
    repeat (3) @(posedge clk);
    #1;
    xact(1'b0, IO_BASE + 32'h4, 32'h0, lat, rd, er);
    check_eq("sw_rd_new", rd, 32'h5A);

    // Errors: misaligned, unmapped, bad IO offset; no side effects.
    xact(1'b0, 32'h12, 32'h0, lat, rd, er);
    check_eq("misal_err", 32'(er), 32'd1);
    check_eq("misal_rd", rd, 32'h0);
    check_eq("misal_lat", 32'(lat), 32'd1);
    xact(1'b0, 32'h8000_0000, 32'h0, lat, rd, er);
    check_eq("unmap_err", 32'(er), 32'd1);
    check_eq("unmap_rd", rd, 32'h0);
    xact(1'b0, IO_BASE + 32'hC, 32'h0, lat, rd, er);
    check_eq("io_unmap_err", 32'(er), 32'd1);
    xact(1'b1, 32'h12, 32'h1111_1111, lat, rd, er);
    check_eq("misal_wr_err", 32'(er), 32'd1);
    xact(1'b1, IO_BASE + 32'h2, 32'h77, lat, rd, er);
    check_eq("misal_led_err", 32'(er), 32'd1);
    check_eq("led_kept", 32'(led_out), 32'hA5);
    xact(1'b0, 32'h10, 32'h0, lat, rd, er);
    check_eq("ram_kept", rd, 32'hDEADBEEF);

    // Back-pressure: response held, new request ignored.
    xact(1'b1, 32'h20, 32'h1234_5678, lat, rd, er);
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0000_0BAD;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check_eq("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("bp_ready_after", 32'(req_ready), 32'd1);
    check_eq("bp_valid_after", 32'(rsp_valid), 32'd0);
    xact(1'b0, 32'h20, 32'h0, lat, rd, er);
    check_eq("bp_no_accept", rd, 32'h1234_5678);

    // Cycle counter: 0 after the write edge, so a read accepted four edges later returns 3.
    req_write = 1'b1; req_addr = IO_BASE + 32'h8; req_wdata = 32'hFFFF_FFFF;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("cyc_wr_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xact(1'b0, IO_BASE + 32'h8, 32'h0, lat, rd, er);
    check_eq("cyc_rd", rd, 32'd3);
    check_eq("cyc_lat", 32'(lat), 32'd1);

    // Reset while a RAM read is in RD_WAIT.
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rst_led", 32'(led_out), 32'h0);
    xact(1'b0, 32'h10, 32'h0, lat, rd, er);
    check_eq("ram_after_rst", rd, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
